// File: rtl/seg7_upd_if.sv
// Decode-event stream between the scan decoder and its consumer.
// The decoder drives the event fields; the consumer drives upd_ready.
interface seg7_upd_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_idx;
  logic [3:0] upd_nibble;
  logic       upd_err;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_nibble,
    output upd_err,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_nibble,
    input  upd_err,
    output upd_ready
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned multi-digit 7-segment display.
// Synchronises the segment/digit lines, waits for them to settle, decodes
// each glyph back to a nibble, keeps a per-digit result register and
// reports every decode as an event through a single-entry output buffer.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_ok,
  seg7_upd_if.master            upd,
  output logic                  overrun
);

  localparam int         SW       = 7 + DIGITS;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]     sync1;
  logic [SW-1:0]     sync2;
  logic [SW-1:0]     prev;
  logic [7:0]        cnt;
  logic              armed;

  logic              same;
  logic              fire;
  logic              evt;
  logic [6:0]        cur_seg;
  logic [DIGITS-1:0] cur_dig;
  logic              dig_onehot;
  logic [2:0]        dig_idx;
  logic [3:0]        glyph_nib;
  logic              glyph_err;

  assign cur_seg = sync2[SW-1:DIGITS];
  assign cur_dig = sync2[DIGITS-1:0];
  assign same    = (sync2 == prev);

  // The decision is made on the edge where the counter steps from
  // STABLE_CYCLES-1 to STABLE_CYCLES; armed keeps it to one event per change
  // and keeps the all-zero state seen right after reset from firing.
  assign fire       = same && armed && (cnt == CNT_FIRE);
  assign dig_onehot = $onehot(cur_dig);
  assign evt        = fire && dig_onehot;

  // Two-flop synchroniser for the whole {seg, dig} bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {seg_in, dig_in};
      sync2 <= sync1;
    end
  end

  // Stability filter: any change restarts the count and re-arms the event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev  <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      prev <= sync2;
      if (!same) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 8'd1;
        end
        if (fire) begin
          armed <= 1'b0;
        end
      end
    end
  end

  // One-hot digit select to binary index; upper index bits stay zero.
  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cur_dig[i]) begin
        dig_idx = 3'(i);
      end
    end
  end

  // Glyph table, segments ordered {g,f,e,d,c,b,a}; lower-case b and d
  // are the usual forms that keep them distinct from 8 and 0.
  always_comb begin
    glyph_nib = 4'h0;
    glyph_err = 1'b0;
    case (cur_seg)
      7'h3F:   glyph_nib = 4'h0;
      7'h06:   glyph_nib = 4'h1;
      7'h5B:   glyph_nib = 4'h2;
      7'h4F:   glyph_nib = 4'h3;
      7'h66:   glyph_nib = 4'h4;
      7'h6D:   glyph_nib = 4'h5;
      7'h7D:   glyph_nib = 4'h6;
      7'h07:   glyph_nib = 4'h7;
      7'h7F:   glyph_nib = 4'h8;
      7'h6F:   glyph_nib = 4'h9;
      7'h77:   glyph_nib = 4'hA;
      7'h7C:   glyph_nib = 4'hB;
      7'h39:   glyph_nib = 4'hC;
      7'h5E:   glyph_nib = 4'hD;
      7'h79:   glyph_nib = 4'hE;
      7'h71:   glyph_nib = 4'hF;
      default: glyph_err = 1'b1;
    endcase
  end

  // Per-digit result registers; updated on every event regardless of the
  // consumer, an invalid glyph keeps the old value but drops the ok flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_val <= '0;
      digit_ok  <= '0;
    end else if (evt) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cur_dig[i]) begin
          if (glyph_err) begin
            digit_ok[i] <= 1'b0;
          end else begin
            digit_val[4*i +: 4] <= glyph_nib;
            digit_ok[i]         <= 1'b1;
          end
        end
      end
    end
  end

  // Single-entry event buffer: newest event wins, and overwriting an
  // unaccepted event leaves a sticky overrun flag. An accept on the same
  // edge as a new event is not a loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd.upd_valid  <= 1'b0;
      upd.upd_idx    <= '0;
      upd.upd_nibble <= '0;
      upd.upd_err    <= 1'b0;
      overrun        <= 1'b0;
    end else if (evt) begin
      if (upd.upd_valid && !upd.upd_ready) begin
        overrun <= 1'b1;
      end
      upd.upd_valid  <= 1'b1;
      upd.upd_idx    <= dig_idx;
      upd.upd_err    <= glyph_err;
      upd.upd_nibble <= glyph_err ? 4'h0 : glyph_nib;
    end else if (upd.upd_valid && upd.upd_ready) begin
      upd.upd_valid <= 1'b0;
    end
  end

endmodule
